sign_narrow_unit: RTL

Streaming 32-to-16-bit signed narrowing unit: the inverse of the datapath's 16-to-32 sign extension. It accepts 32-bit two's-complement words over a valid/ready handshake and emits 16-bit results through a 2-entry output buffer. Each result carries a flag saying whether the word was exactly representable in 16 bits. A sticky counter records every word that was not. It sits on the store/immediate-packing path between the register file read port and halfword consumers.

---
 rtl/sign_narrow_unit.sv | 89 ++++++++
 1 files changed

// File: rtl/sign_narrow_unit.sv
// Narrows 32-bit signed words to 16 bits, with optional saturation and a per-word fit flag.
// Results pass through a 2-entry FIFO, and a saturating counter tallies the words that did not fit.
module sign_narrow_unit #(
  parameter bit SAT_EN = 1'b1,
  parameter int CNT_W  = 8
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             InValid,
  output logic             InReady,
  input  logic [31:0]      In,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [15:0]      Out,
  output logic             OutFits,
  output logic [CNT_W-1:0] OvfCount,
  input  logic             ClrCount
);

  // Handshake: a transfer happens on a rising edge where valid & ready are both high.
  // Ready never depends on the partner's valid, and a held head entry stays stable until popped.
  logic [16:0]      mem_q [2];
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       count_q, count_d;
  logic [CNT_W-1:0] ovf_q, ovf_d;
  logic             accept, pop, fits;
  logic [15:0]      narrowed;

  // The word fits when bits 31..15 are all copies of one sign bit.
  assign fits = (&In[31:15]) | ~(|In[31:15]);

  always_comb begin
    narrowed = In[15:0];
    if (!fits && SAT_EN) begin
      narrowed = In[31] ? 16'h8000 : 16'h7FFF;
    end
  end

  assign InReady  = Reset_n & (count_q != 2'd2);
  assign OutValid = (count_q != 2'd0);
  assign accept   = InValid & InReady;
  assign pop      = OutValid & OutReady;
  assign Out      = mem_q[rd_ptr_q][15:0];
  assign OutFits  = mem_q[rd_ptr_q][16];
  assign OvfCount = ovf_q;

  always_comb begin
    count_d = count_q;
    case ({accept, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // A clear combined with a non-fitting accept leaves the counter at 1, not 0.
  always_comb begin
    ovf_d = ovf_q;
    if (ClrCount) begin
      ovf_d = (accept && !fits) ? CNT_W'(1) : '0;
    end else if (accept && !fits && (ovf_q != {CNT_W{1'b1}})) begin
      ovf_d = ovf_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      ovf_q    <= '0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      if (accept) wr_ptr_q <= ~wr_ptr_q;
      if (pop)    rd_ptr_q <= ~rd_ptr_q;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      mem_q[0] <= 17'd0;
      mem_q[1] <= 17'd0;
    end else if (accept) begin
      mem_q[wr_ptr_q] <= {fits, narrowed};
    end
  end

endmodule
